// File: rtl/mram_op_scheduler.sv
// Two-requester scheduler for time-sliced MRAM operations: arbitrates, holds the
// controller out of reset for one slot, then pulses done. Macro MRAM_SCHED_ROUND_ROBIN_EN selects round-robin.
module mram_op_scheduler #(
    parameter int unsigned WR_SLOT = 23,
    parameter int unsigned RD_SLOT = 41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       owner,
    output logic [2:0] ctrl_sel,
    output logic       ctrl_rst,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [5:0] WR_LAST = 6'(WR_SLOT - 1);
    localparam logic [5:0] RD_LAST = 6'(RD_SLOT - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] req_q;
    logic [2:0] op0_q, op1_q;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       busy_q, busy_d;
    logic       owner_q, owner_d;
    logic [2:0] sel_q, sel_d;
    logic       crst_q, crst_d;
    logic       nop_q, nop_d;

    logic       win;
    logic [2:0] op_w;
    logic [5:0] slot_last;
    logic [1:0] owner_mask;

    // Requests and commands are registered first, so a grant lands one edge after sampling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q <= 2'b00;
            op0_q <= 3'b000;
            op1_q <= 3'b000;
        end else begin
            req_q <= req;
            op0_q <= op0;
            op1_q <= op1;
        end
    end

`ifdef MRAM_SCHED_ROUND_ROBIN_EN
    // ptr_q names the requester that wins a tie; it flips away from every grantee.
    logic ptr_q, ptr_d;

    always_comb begin
        win = (req_q == 2'b11) ? ptr_q : ~req_q[0];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && req_q != 2'b00) begin
            ptr_d = ~win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win = ~req_q[0];
    end
`endif

    always_comb begin
        op_w       = win ? op1_q : op0_q;
        slot_last  = sel_q[0] ? WR_LAST : RD_LAST;
        owner_mask = owner_q ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        busy_d  = busy_q;
        owner_d = owner_q;
        sel_d   = sel_q;
        crst_d  = crst_q;
        nop_d   = nop_q;
        case (state_q)
            S_IDLE: begin
                crst_d = 1'b1;
                busy_d = 1'b0;
                if (req_q != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    owner_d = win;
                    sel_d   = op_w;
                    cnt_d   = 6'd0;
                    if (op_w[2:1] == 2'b00) begin
                        // A nop never releases the controller; it only completes the handshake.
                        state_d = S_FIN;
                        nop_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        nop_d   = 1'b0;
                        crst_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == slot_last) begin
                    state_d = S_FIN;
                    crst_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = owner_mask;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                nop_d   = 1'b0;
                if (nop_q) begin
                    done_d = owner_mask;
                end
            end
            default: begin
                state_d = S_IDLE;
                crst_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            sel_q   <= 3'b000;
            crst_q  <= 1'b1;
            nop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            crst_q  <= crst_d;
            nop_q   <= nop_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign ctrl_sel  = sel_q;
    assign ctrl_rst  = crst_q;
    assign dbg_state = state_q;

endmodule
